branch_ctrl_ras: RTL and testbench

Next-generation PC/branch controller for the tiny core. It owns the registered program counter, the stored ALU flags and a return-address stack (RAS). It resolves JMP/BRZ/BRNZ/BRNS as PC-relative branches and adds CALL/RET. It sits between ControlUnit (branch_type, offset, enable) and instruction fetch (pc_out), and is parametrised in PC width and RAS depth.

---
 rtl/branch_ctrl_ras.sv | 141 ++++++++++++++
 tb/tb_branch_ctrl_ras.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl_ras.sv
// rtl/branch_ctrl_ras.sv - PC/branch controller with stored ALU flags and circular return-address stack
module branch_ctrl_ras #(
  parameter int                     PC_WIDTH  = 16,
  parameter int                     RAS_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          branch_enable,
  input  logic [3:0]                    branch_type,
  input  logic [PC_WIDTH-1:0]           branch_offset,
  input  logic [1:0]                    flags_in,
  input  logic                          flags_we,
  output logic [PC_WIDTH-1:0]           pc_out,
  output logic                          taken,
  output logic [1:0]                    stored_flags,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_overflow,
  output logic                          ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [3:0] BT_JMP  = 4'b1001;
  localparam logic [3:0] BT_BRZ  = 4'b1010;
  localparam logic [3:0] BT_BRNZ = 4'b1011;
  localparam logic [3:0] BT_BRNS = 4'b1100;
  localparam logic [3:0] BT_CALL = 4'b1101;
  localparam logic [3:0] BT_RET  = 4'b1110;

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_taken;
  logic [1:0]          r_flags;
  logic [PTR_W-1:0]    r_top;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_underflow;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];

  logic                w_redirect;
  logic                w_push;
  logic                w_pop;
  logic                w_ret_empty;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_rel;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PTR_W-1:0]    w_top_inc;

  // Power-of-two depth lets the pointer and PC arithmetic wrap naturally.
  assign w_pc_inc  = r_pc + PC_WIDTH'(1);
  assign w_pc_rel  = r_pc + branch_offset;
  assign w_top_inc = r_top + PTR_W'(1);

  // Decode the branch against the flags held before this edge (no flags_in bypass).
  always_comb begin
    w_redirect  = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ret_empty = 1'b0;
    if (branch_enable) begin
      case (branch_type)
        BT_JMP:  w_redirect = 1'b1;
        BT_BRZ:  w_redirect = r_flags[0];
        BT_BRNZ: w_redirect = ~r_flags[0];
        BT_BRNS: w_redirect = ~r_flags[1];
        BT_CALL: begin
          w_redirect = 1'b1;
          w_push     = 1'b1;
        end
        BT_RET: begin
          if (r_count != '0) begin
            w_redirect = 1'b1;
            w_pop      = 1'b1;
          end else begin
            w_ret_empty = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Select the next PC: return address, relative target, or sequential.
  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_pop)
      w_pc_next = r_ras[r_top];
    else if (w_redirect)
      w_pc_next = w_pc_rel;
  end

  // Control state: flags load even when stalled; PC, taken and RAS hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_taken     <= 1'b0;
      r_flags     <= 2'b00;
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (flags_we)
        r_flags <= flags_in;
      if (!stall) begin
        r_pc    <= w_pc_next;
        r_taken <= w_redirect;
        if (w_push) begin
          r_top <= w_top_inc;
          if (r_count == RAS_FULL)
            r_overflow <= 1'b1;
          else
            r_count <= r_count + 1'b1;
        end
        if (w_pop) begin
          r_top   <= r_top - 1'b1;
          r_count <= r_count - 1'b1;
        end
        if (w_ret_empty)
          r_underflow <= 1'b1;
      end
    end
  end

  // Return-address storage; a push when full simply overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (!rst && !stall && w_push)
      r_ras[w_top_inc] <= w_pc_inc;
  end

  assign pc_out        = r_pc;
  assign taken         = r_taken;
  assign stored_flags  = r_flags;
  assign ras_count     = r_count;
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_branch_ctrl_ras.sv
// tb/tb_branch_ctrl_ras.sv - directed table-driven bench for branch_ctrl_ras
module tb_branch_ctrl_ras;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_enable;
  logic [3:0]  branch_type;
  logic [15:0] branch_offset;
  logic [1:0]  flags_in;
  logic        flags_we;
  logic [15:0] pc_out;
  logic        taken;
  logic [1:0]  stored_flags;
  logic [3:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks = 0;
  int errors = 0;

  branch_ctrl_ras #(.PC_WIDTH(16), .RAS_DEPTH(8), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_enable (branch_enable),
    .branch_type   (branch_type),
    .branch_offset (branch_offset),
    .flags_in      (flags_in),
    .flags_we      (flags_we),
    .pc_out        (pc_out),
    .taken         (taken),
    .stored_flags  (stored_flags),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        en;
    logic [3:0]  typ;
    logic [15:0] off;
    logic [1:0]  fi;
    logic        fwe;
    logic [15:0] pc;
    logic        tk;
    logic [1:0]  fl;
    logic [3:0]  cnt;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] JMP  = 4'b1001;
  localparam logic [3:0] BRZ  = 4'b1010;
  localparam logic [3:0] BRNZ = 4'b1011;
  localparam logic [3:0] BRNS = 4'b1100;
  localparam logic [3:0] CALL = 4'b1101;
  localparam logic [3:0] RET  = 4'b1110;
  localparam logic [3:0] NONE = 4'b0000;

  task automatic add(input logic r, input logic s, input logic e, input logic [3:0] t,
                     input logic [15:0] o, input logic [1:0] fi, input logic fwe,
                     input logic [15:0] pc, input logic tk, input logic [1:0] fl,
                     input logic [3:0] cnt, input logic ov, input logic un);
    vec_t v;
    v.rst = r; v.stall = s; v.en = e; v.typ = t; v.off = o; v.fi = fi; v.fwe = fwe;
    v.pc = pc; v.tk = tk; v.fl = fl; v.cnt = cnt; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge happen, return at the next falling edge.
  task automatic step(input logic r, input logic s, input logic e, input logic [3:0] t,
                      input logic [15:0] o, input logic [1:0] fi, input logic fwe);
    rst = r; stall = s; branch_enable = e; branch_type = t;
    branch_offset = o; flags_in = fi; flags_we = fwe;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_enable = 1'b0; branch_type = NONE;
    branch_offset = 16'h0000; flags_in = 2'b00; flags_we = 1'b0;

    //   rst   stall en    type  offset    fi     fwe  | pc        tk    fl     cnt   ov    un
    add(1'b1, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0001, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0002, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0003, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0004, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, JMP,  16'h000C, 2'b00, 1'b0, 16'h0010, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b01, 1'b1, 16'h0011, 1'b0, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, BRZ,  16'hFFFA, 2'b00, 1'b0, 16'h000B, 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, BRNZ, 16'h0005, 2'b00, 1'b0, 16'h000C, 1'b0, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b1, 16'h000D, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, BRZ,  16'h0020, 2'b01, 1'b1, 16'h000E, 1'b0, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, BRZ,  16'h0010, 2'b00, 1'b0, 16'h001E, 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, BRNS, 16'h0002, 2'b00, 1'b0, 16'h0020, 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, CALL, 16'h0100, 2'b00, 1'b0, 16'h0120, 1'b1, 2'b01, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, RET,  16'h0000, 2'b00, 1'b0, 16'h0021, 1'b1, 2'b01, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, RET,  16'h0000, 2'b00, 1'b0, 16'h0022, 1'b0, 2'b01, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, JMP,  16'h0100, 2'b00, 1'b0, 16'h0023, 1'b0, 2'b01, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, JMP,  16'h0002, 2'b00, 1'b0, 16'h0025, 1'b1, 2'b01, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, JMP,  16'h0100, 2'b10, 1'b1, 16'h0025, 1'b1, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, JMP,  16'h0100, 2'b00, 1'b0, 16'h0125, 1'b1, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, BRNS, 16'h0004, 2'b00, 1'b0, 16'h0126, 1'b0, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, JMP,  16'hFED9, 2'b00, 1'b0, 16'hFFFF, 1'b1, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0001, 1'b0, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, NONE, 16'h0000, 2'b00, 1'b0, 16'h0001, 1'b0, 2'b10, 4'd0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, JMP,  16'h0100, 2'b01, 1'b1, 16'h0000, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, CALL, 16'h0010, 2'b00, 1'b0, 16'h0010, 1'b1, 2'b00, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, RET,  16'h0000, 2'b00, 1'b0, 16'h0010, 1'b1, 2'b00, 4'd1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, RET,  16'h0000, 2'b00, 1'b0, 16'h0001, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'hF, 16'h0040, 2'b00, 1'b0, 16'h0002, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].en, vecs[i].typ, vecs[i].off, vecs[i].fi, vecs[i].fwe);
      chk($sformatf("v%0d pc", i),    pc_out,                 vecs[i].pc);
      chk($sformatf("v%0d taken", i), 16'(taken),             16'(vecs[i].tk));
      chk($sformatf("v%0d flags", i), 16'(stored_flags),      16'(vecs[i].fl));
      chk($sformatf("v%0d count", i), 16'(ras_count),         16'(vecs[i].cnt));
      chk($sformatf("v%0d ovf", i),   16'(ras_overflow),      16'(vecs[i].ov));
      chk($sformatf("v%0d unf", i),   16'(ras_underflow),     16'(vecs[i].un));
    end

    // Nine nested CALLs into an 8-deep stack; CALL k sits at pc (k-1)*0x10 and pushes (k-1)*0x10+1.
    step(1'b1, 1'b0, 1'b0, NONE, 16'h0000, 2'b00, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b1, CALL, 16'h0010, 2'b00, 1'b0);
      chk($sformatf("call%0d pc", k),    pc_out,            16'(k * 16));
      chk($sformatf("call%0d count", k), 16'(ras_count),    16'((k > 8) ? 8 : k));
      chk($sformatf("call%0d ovf", k),   16'(ras_overflow), 16'((k > 8) ? 1 : 0));
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 1'b0, 1'b1, RET, 16'h0000, 2'b00, 1'b0);
      chk($sformatf("ret%0d pc", j),    pc_out,         16'((8 - j) * 16 + 1));
      chk($sformatf("ret%0d count", j), 16'(ras_count), 16'(7 - j));
      chk($sformatf("ret%0d taken", j), 16'(taken),     16'h0001);
    end
    step(1'b0, 1'b0, 1'b1, RET, 16'h0000, 2'b00, 1'b0);
    chk("ret_empty pc",    pc_out,             16'h0012);
    chk("ret_empty taken", 16'(taken),         16'h0000);
    chk("ret_empty unf",   16'(ras_underflow), 16'h0001);
    chk("ret_empty ovf",   16'(ras_overflow),  16'h0001);
    chk("ret_empty count", 16'(ras_count),     16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
